// File: rtl/misc_pkg.sv
// Shared core helpers: circular-priority one-hot picker used by the
// result-bus arbiters. Vectors narrower than RR_MAX are zero-extended.
package misc_pkg;

   localparam int RR_MAX = 32;

   // Lowest set bit of valid at or above ptr; otherwise lowest set bit overall.
   // Zero-extended upper bits are never valid, so wrapping at RR_MAX-1 is
   // equivalent to wrapping at the caller's real width.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                 input logic [RR_MAX-1:0] ptr);
      logic [RR_MAX-1:0] hi;
      hi = valid & ~(ptr - RR_MAX'(1));
      if (hi != '0) rr_pick = hi & (~hi + RR_MAX'(1));
      else          rr_pick = valid & (~valid + RR_MAX'(1));
   endfunction

endpackage

// File: rtl/result_bus_if.sv
// Requester and consumer side of the shared result bus.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and data stable until it sees ready.
interface result_bus_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
);
   logic                             flush;
   logic [N_REQ-1:0]                 req_valid;
   logic [N_REQ-1:0][WIDTH-1:0]      req_data;
   logic [N_REQ-1:0]                 req_ready;
   logic                             out_valid;
   logic [WIDTH-1:0]                 out_data;
   logic [N_REQ-1:0]                 out_src;
   logic                             out_ready;

   modport slave (
      input  flush, req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_src
   );

   modport master (
      output flush, req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/onehot_mux.sv
// N-way one-hot select mux; an all-zero select yields zero.
module onehot_mux #(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic [N-1:0]            sel_i,
   input  logic [N-1:0][WIDTH-1:0] data_i,
   output logic [WIDTH-1:0]        data_o
);
   always_comb begin
      data_o = '0;
      for (int i = 0; i < N; i++) begin
         data_o = data_o | (data_i[i] & {WIDTH{sel_i[i]}});
      end
   end
endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing one registered result slot among N_REQ
// writeback ports; the winner rotates to lowest priority after each accept.
module result_bus_arbiter
   import misc_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_aL,
   result_bus_if.slave      bus,
   output logic [N_REQ-1:0] dbg_ptr_o
);
   logic [N_REQ-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [N_REQ-1:0] out_src_q, out_src_d;
   logic [WIDTH-1:0] mux_data;
   logic             space;
   logic             accept;

   // N_REQ must not exceed RR_MAX for the widening cast to be lossless.
   assign gnt    = N_REQ'(rr_pick(RR_MAX'(bus.req_valid), RR_MAX'(ptr_q)));
   assign space  = !out_valid_q || bus.out_ready;
   assign accept = rst_aL && space && !bus.flush && (gnt != '0);

   assign bus.req_ready = accept ? gnt : '0;

   onehot_mux #(.N(N_REQ), .WIDTH(WIDTH)) u_mux (
      .sel_i  (gnt),
      .data_i (bus.req_data),
      .data_o (mux_data)
   );

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         out_src_d   = '0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
         out_src_d   = gnt;
         ptr_d       = {gnt[N_REQ-2:0], gnt[N_REQ-1]};
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
         out_src_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         ptr_q       <= N_REQ'(1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign dbg_ptr_o     = ptr_q;
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: directed scenarios then random
// traffic, checked against a circular-search reference model.
module tb_result_bus_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_aL = 1'b0;
   logic [N-1:0] ptr_o;

   int checks = 0;
   int errors = 0;

   // Expected slot contents in acceptance order: {src, data}
   logic [N+W-1:0] exp_q[$];
   int             m_ptr = 0;
   logic           m_full = 1'b0;

   result_bus_if #(.N_REQ(N), .WIDTH(W)) bus ();

   result_bus_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .bus       (bus),
      .dbg_ptr_o (ptr_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // First valid requester at or after index p, wrapping around.
   function automatic int model_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      int w;
      if (bus.flush || (m_full && !bus.out_ready)) return '0;
      w = model_pick(bus.req_valid, m_ptr);
      if (w < 0) return '0;
      return N'(1) << w;
   endfunction

   // Reference model: tracks pointer and slot occupancy, pushes each accept.
   initial begin
      forever begin
         @(posedge clk or negedge rst_aL);
         if (!rst_aL) begin
            m_ptr  = 0;
            m_full = 1'b0;
            exp_q.delete();
         end else begin
            automatic int w = model_pick(bus.req_valid, m_ptr);
            automatic bit space = !m_full || bus.out_ready;
            if (bus.flush) begin
               m_full = 1'b0;
            end else if (space && w >= 0) begin
               exp_q.push_back({N'(1) << w, bus.req_data[w]});
               m_full = 1'b1;
               m_ptr  = (w + 1) % N;
            end else if (m_full && bus.out_ready) begin
               m_full = 1'b0;
            end
         end
      end
   end

   // Monitor: compares the presented slot with the queue head, pops on handoff.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_aL) begin
            chk("req_ready_in_reset", 64'(bus.req_ready), 64'(0));
         end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(model_ready()));
            chk("ptr", 64'(ptr_o), 64'(N'(1) << m_ptr));
            chk("ptr_onehot", 64'($onehot(ptr_o)), 64'(1));
            chk("out_valid", 64'(bus.out_valid), 64'(m_full));
            if (bus.out_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output actual=%0h expected=none at %0t", bus.out_data, $time);
               end else begin
                  automatic logic [N+W-1:0] e = exp_q[0];
                  chk("out_src", 64'(bus.out_src), 64'(e[N+W-1:W]));
                  chk("out_data", 64'(bus.out_data), 64'(e[W-1:0]));
                  if (bus.flush || bus.out_ready) void'(exp_q.pop_front());
               end
            end else begin
               chk("out_src_empty", 64'(bus.out_src), 64'(0));
            end
         end
      end
   end

   task automatic step(input logic [N-1:0] v, input logic ordy, input logic fl);
      bus.req_valid = v;
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] acc;
      bus.req_valid = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      for (int i = 0; i < N; i++) bus.req_data[i] = 32'h0000_00A0 + 32'(i);

      // Power-on reset with all requesters asking.
      bus.req_valid = 4'b1111;
      #3;
      chk("por_out_valid", 64'(bus.out_valid), 64'(0));
      chk("por_out_src", 64'(bus.out_src), 64'(0));
      chk("por_out_data", 64'(bus.out_data), 64'(0));
      chk("por_req_ready", 64'(bus.req_ready), 64'(0));
      bus.req_valid = '0;
      @(negedge clk);
      #2 rst_aL = 1'b1;
      @(posedge clk);
      #1;

      // Fairness: 0,1,2,3,0,1,2 leaves the pointer at bit 3.
      for (int i = 0; i < 7; i++) step(4'b1111, 1'b1, 1'b0);
      // Wrap and skip: from bit 3 with 0101 pick 0, then 2.
      step(4'b0101, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);

      // Backpressure on a full slot.
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);

      // Flush drops the slot and blocks the accept in the same cycle.
      bus.req_data[0] = 32'hDEAD_BEEF;
      step(4'b0001, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b1);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);

      // Idle: pointer holds, slot drains after one out_ready.
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // Reset mid-transfer with the slot full.
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      rst_aL = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_rst_out_src", 64'(bus.out_src), 64'(0));
      chk("mid_rst_out_data", 64'(bus.out_data), 64'(0));
      chk("mid_rst_ptr", 64'(ptr_o), 64'(1));
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
      @(negedge clk);
      #2 rst_aL = 1'b1;
      @(posedge clk);
      #1;
      step(4'b1111, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);

      // Random traffic; unaccepted requesters keep valid and data stable.
      bus.req_valid = '0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!(bus.req_valid[i] && !acc[i])) begin
               bus.req_valid[i] = 1'($urandom_range(0, 1));
               bus.req_data[i]  = $urandom;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
      end

      // Drain and confirm nothing was left unreported.
      bus.req_valid = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
